// File: rtl/merge_nx1_rr.sv
// -----------------------------------------------------------------------------
// merge_nx1_rr
//   Parametrised N-to-1 merge stage. Each of N_CH write channels feeds its own
//   FIFO; a round-robin arbiter drains the FIFOs into a single show-ahead
//   output register that the consumer pops with `ren`.
//
// Optional feature macro: MERGE_FREEZE_EN
//   defined     : freeze[i] = 1 when FIFO i holds >= DEPTH-1 words
//   not defined : freeze is tied to 0
//
// Ports
//   clk_i   in   1              single clock, rising edge
//   reset   in   1              synchronous, active-high reset
//   wen     in   N_CH           per-channel write strobe
//   i_data  in   N_CH*DATA_W    channel i at [i*DATA_W +: DATA_W]
//   ren     in   1              consumer pop, effective only while valid=1
//   valid   out  1              output register holds a word
//   o_data  out  DATA_W         output word
//   o_chan  out  CH_W           source channel of o_data
//   ovf     out  N_CH           sticky per-channel overflow (dropped write)
//   freeze  out  N_CH           per-channel stall request
// -----------------------------------------------------------------------------

// Per-channel FIFO. Head word is visible combinationally (show-ahead).
module merge_nx1_rr_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              freeze_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]                   wr_q, rd_q;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    // On a full FIFO with simultaneous push and pop the write lands in the
    // slot being read out this same edge, which is safe: the head is sampled
    // before the write takes effect.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

`ifdef MERGE_FREEZE_EN
    logic [AW:0] occ;
    assign occ      = wr_q - rd_q;
    assign freeze_o = (occ >= (AW+1)'(DEPTH-1));
`else
    assign freeze_o = 1'b0;
`endif
endmodule

module merge_nx1_rr #(
    parameter  int N_CH   = 9,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic [N_CH-1:0]        wen,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic                   ren,
    output logic                   valid,
    output logic [DATA_W-1:0]      o_data,
    output logic [CH_W-1:0]        o_chan,
    output logic [N_CH-1:0]        ovf,
    output logic [N_CH-1:0]        freeze
);
    logic [N_CH-1:0][DATA_W-1:0] head;
    logic [N_CH-1:0]             empty, full, push, pop;

    logic                        valid_q, valid_d;
    logic [DATA_W-1:0]           data_q, data_d;
    logic [CH_W-1:0]             chan_q, chan_d;
    logic [CH_W-1:0]             last_q, last_d;
    logic [N_CH-1:0]             ovf_q, ovf_d;

    logic                        load;
    logic                        gnt_vld;
    logic [CH_W-1:0]             gnt;
    int                          idx;

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        merge_nx1_rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i    (clk_i),
            .reset    (reset),
            .push_i   (push[i]),
            .pop_i    (pop[i]),
            .wdata_i  (i_data[i*DATA_W +: DATA_W]),
            .rdata_o  (head[i]),
            .empty_o  (empty[i]),
            .full_o   (full[i]),
            .freeze_o (freeze[i])
        );
    end

    assign load = !valid_q || ren;

    // Round-robin search starting just after the last granted channel.
    // Uses occupancy before this edge's writes, so there is no bypass.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_vld && !empty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CH_W'(idx);
            end
        end
    end

    // A full FIFO still accepts a write when the arbiter pops it this edge.
    always_comb begin
        pop = '0;
        if (load && gnt_vld) pop[gnt] = 1'b1;
        push  = wen & (~full | pop);
        ovf_d = ovf_q | (wen & full & ~pop);
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        if (load) begin
            valid_d = gnt_vld;
            if (gnt_vld) begin
                data_d = head[gnt];
                chan_d = gnt;
                last_d = gnt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= CH_W'(N_CH-1);
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid  = valid_q;
    assign o_data = data_q;
    assign o_chan = chan_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_merge_nx1_rr.sv
module tb_merge_nx1_rr;
    localparam int N_CH   = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CH_W   = $clog2(N_CH);

    logic                   clk_i = 1'b0;
    logic                   reset;
    logic [N_CH-1:0]        wen;
    logic [N_CH*DATA_W-1:0] i_data;
    logic                   ren;
    logic                   valid;
    logic [DATA_W-1:0]      o_data;
    logic [CH_W-1:0]        o_chan;
    logic [N_CH-1:0]        ovf;
    logic [N_CH-1:0]        freeze;

    int checks = 0;
    int errors = 0;

    merge_nx1_rr #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .reset  (reset),
        .wen    (wen),
        .i_data (i_data),
        .ren    (ren),
        .valid  (valid),
        .o_data (o_data),
        .o_chan (o_chan),
        .ovf    (ovf),
        .freeze (freeze)
    );

    always #5 clk_i = ~clk_i;

`ifdef MERGE_FREEZE_EN
    localparam logic FRZ = 1'b1;
`else
    localparam logic FRZ = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int ch, input logic [7:0] d);
        wen[ch] = 1'b1;
        i_data[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        reset  = 1'b1;
        wen    = '1;
        i_data = {N_CH{8'h5A}};
        ren    = 1'b0;
        #1;

        // Reset with all writes asserted
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_valid",  valid,  0);
            chk("rst_data",   o_data, 0);
            chk("rst_chan",   o_chan, 0);
            chk("rst_ovf",    ovf,    0);
            chk("rst_freeze", freeze, 0);
        end
        reset = 1'b0;
        wen   = '0;
        step();
        chk("post_rst_valid", valid, 0);
        step();
        chk("post_rst_valid2", valid, 0);

        // Single write on channel 4
        wr(4, 8'hA5);
        step();
        wen = '0;
        chk("single_nobypass", valid, 0);
        step();
        chk("single_valid", valid, 1);
        chk("single_data",  o_data, 8'hA5);
        chk("single_chan",  o_chan, 4);
        step();
        chk("single_hold",  valid, 1);
        chk("single_hold_d", o_data, 8'hA5);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("single_popped", valid, 0);

        // Round-robin fairness: reset so last=N_CH-1
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < N_CH; c++) wr(c, 8'(16*c + n));
            step();
        end
        wen = '0;
        step();
        ren = 1'b1;
        for (int s = 0; s < 2*N_CH; s++) begin
            chk("rr_valid", valid, 1);
            chk("rr_chan",  o_chan, s % N_CH);
            chk("rr_data",  o_data, 16*(s % N_CH) + s / N_CH);
            step();
        end
        chk("rr_drained", valid, 0);
        ren = 1'b0;

        // Wrap: last=7, only channels 2 and 8 non-empty
        wr(7, 8'h77);
        step();
        wen = '0;
        step();
        chk("wrap_ch7", o_chan, 7);
        wr(2, 8'h22);
        wr(8, 8'h88);
        step();
        wen = '0;
        ren = 1'b1;
        step();
        chk("wrap_first_chan", o_chan, 8);
        chk("wrap_first_data", o_data, 8'h88);
        step();
        chk("wrap_second_chan", o_chan, 2);
        chk("wrap_second_data", o_data, 8'h22);
        step();
        chk("wrap_drained", valid, 0);
        ren = 1'b0;

        // Overflow on channel 1: words 0x30..0x35, sixth is dropped
        for (int n = 0; n < 6; n++) begin
            wr(1, 8'(8'h30 + n));
            step();
            if (n == 2) chk("ovf_freeze_occ2", freeze, 0);
            if (n == 3) chk("ovf_freeze_occ3", freeze, {7'b0, FRZ, 1'b0});
            if (n == 4) chk("ovf_before", ovf, 0);
        end
        wen = '0;
        chk("ovf_set",  ovf, 9'h002);
        chk("ovf_head", o_data, 8'h30);

        // Full FIFO plus simultaneous pop accepts the write
        ren = 1'b1;
        wr(1, 8'h36);
        step();
        wen = '0;
        chk("fullpop_data",   o_data, 8'h31);
        chk("fullpop_ovf",    ovf, 9'h002);
        chk("fullpop_freeze", freeze, {7'b0, FRZ, 1'b0});
        for (int n = 0; n < 4; n++) begin
            step();
            chk("fullpop_drain_v", valid, 1);
            chk("fullpop_drain_d", o_data, (n == 3) ? 8'h36 : 8'(8'h32 + n));
        end
        step();
        chk("fullpop_empty", valid, 0);
        ren = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
